// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and decoder-side signal bundle for keypad_scan_ctrl.
// master = keypad/pin side that drives the columns, slave = the scan controller.
interface keypad_scan_ctrl_if;
    logic [3:0] cols_n;
    logic [3:0] rows;
    logic [7:0] total_val;
    logic       key_valid;
    logic       key_new;

    modport master (output cols_n, input rows, total_val, key_valid, key_new);
    modport slave  (input cols_n, output rows, total_val, key_valid, key_new);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with column synchronizer, press/release debounce and key strobe.
// Optional auto-repeat of key_new while a key is held: define KEY_REPEAT_EN.
//
// state    | meaning
// SCAN     | drive one row per dwell period, look for a low column at dwell end
// DEBOUNCE | row frozen, require DEBOUNCE_CNT matching samples of the candidate
// HELD     | key accepted, row frozen, wait for all columns high
// RELEASE  | require DEBOUNCE_CNT all-high samples before resuming the scan
module keypad_scan_ctrl #(
    parameter int SCAN_DIV      = 16,
    parameter int DEBOUNCE_CNT  = 8,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    keypad_scan_ctrl_if.slave   kp
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    state_t          state_q;
    logic [3:0]      cols_m_q;
    logic [3:0]      cols_s_q;
    logic [3:0]      cand_q;
    logic [3:0]      rows_q;
    logic [DW-1:0]   dwell_q;
    logic [BW-1:0]   deb_q;
    logic [7:0]      total_q;
    logic            valid_q;
    logic            new_q;
    logic [3:0]      rows_d;
    logic            idle_d;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   rep_q;
`endif

    assign rows_d = {rows_q[0], rows_q[3:1]};
    assign idle_d = (cols_s_q == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SCAN;
            cols_m_q <= 4'hF;
            cols_s_q <= 4'hF;
            cand_q   <= 4'hF;
            rows_q   <= 4'b1000;
            dwell_q  <= '0;
            deb_q    <= '0;
            total_q  <= 8'h0F;
            valid_q  <= 1'b0;
            new_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            cols_m_q <= kp.cols_n;
            cols_s_q <= cols_m_q;
            new_q    <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (idle_d) begin
                            rows_q <= rows_d;
                        end else begin
                            cand_q  <= cols_s_q;
                            deb_q   <= '0;
                            state_q <= DEBOUNCE;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cols_s_q != cand_q) begin
                        rows_q  <= rows_d;
                        dwell_q <= '0;
                        state_q <= SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        total_q <= {rows_q, cand_q};
                        valid_q <= 1'b1;
                        new_q   <= 1'b1;
                        state_q <= HELD;
`ifdef KEY_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                HELD: begin
                    if (idle_d) begin
                        deb_q   <= '0;
                        state_q <= RELEASE;
`ifdef KEY_REPEAT_EN
                        rep_q   <= '0;
                    end else if (rep_q == REP_LAST) begin
                        rep_q <= '0;
                        new_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
`ifdef KEY_REPEAT_EN
                    rep_q <= '0;
`endif
                    // a column dropping low again is treated as the same key still held
                    if (!idle_d) begin
                        state_q <= HELD;
                    end else if (deb_q == DEB_LAST) begin
                        valid_q <= 1'b0;
                        rows_q  <= rows_d;
                        dwell_q <= '0;
                        state_q <= SCAN;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.rows      = rows_q;
    assign kp.total_val = total_q;
    assign kp.key_valid = valid_q;
    assign kp.key_new   = new_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad matrix model drives the columns
// from the driven row; table vectors, corner sequences and random presses are checked.
module tb_keypad_scan_ctrl;

    logic clk;
    logic reset;
    logic [3:0] key_mask [4];
    logic [3:0] cols_n_m;
    int n_cmp;
    int n_err;
    int pulses;
    int cyc;
    int pulse_q [$];

    keypad_scan_ctrl_if kp_if ();

    keypad_scan_ctrl #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (8),
        .REPEAT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pressed keys pull their column low only while their row is driven
    always_comb begin
        cols_n_m = 4'hF;
        for (int r = 0; r < 4; r++)
            if (kp_if.rows[r] === 1'b1) cols_n_m = cols_n_m & ~key_mask[r];
    end
    assign kp_if.cols_n = cols_n_m;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (kp_if.key_new === 1'b1) begin
            pulses = pulses + 1;
            pulse_q.push_back(cyc);
        end
    end

    typedef struct {
        int         row;
        logic [3:0] mask;
        logic [7:0] exp_tv;
        string      nm;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_new(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (kp_if.key_new === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_valid_low(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (kp_if.key_valid === 1'b0) ok = 1'b1;
        end
    endtask

    // called right after reset is released on a negedge: row k changes every 4 cycles
    task automatic scan_check(input int n, input string nm);
        int hi;
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({nm, " rows"}, 32'(kp_if.rows), 32'(4'b1000 >> (((k + 1) / 4) % 4)));
            if (kp_if.key_valid !== 1'b0 || kp_if.key_new !== 1'b0) hi++;
        end
        check({nm, " outputs quiet"}, 32'(hi), 32'd0);
    endtask

    task automatic press_check(input int r, input logic [3:0] m, input logic [7:0] exp_tv,
                               input int hold, input string nm);
        bit ok;
        int p0;
        logic [3:0] exp_rows;
        exp_rows = (r == 0) ? 4'b1000 : 4'(1 << (r - 1));
        #1 p0 = pulses;
        key_mask[r] = m;
        wait_new(200, ok);
        check({nm, " accepted"}, 32'(ok), 32'd1);
        check({nm, " total_val"}, 32'(kp_if.total_val), 32'(exp_tv));
        check({nm, " key_valid"}, 32'(kp_if.key_valid), 32'd1);
        repeat (hold) @(negedge clk);
        key_mask[r] = 4'h0;
        wait_valid_low(60, ok);
        check({nm, " released"}, 32'(ok), 32'd1);
        check({nm, " rows after release"}, 32'(kp_if.rows), 32'(exp_rows));
        check({nm, " total_val kept"}, 32'(kp_if.total_val), 32'(exp_tv));
        #1 check({nm, " key_new count"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        bit ok;
        int p0;
        int lows;
        int t0;
        int n_exp;
        int r;
        logic [3:0] m;

        tbl[0] = '{2, 4'b0010, 8'h4D, "key5"};
        tbl[1] = '{3, 4'b1000, 8'h87, "keyA"};
        tbl[2] = '{0, 4'b0100, 8'h1B, "keyF"};
        tbl[3] = '{3, 4'b0001, 8'h8E, "key1"};
        tbl[4] = '{1, 4'b0011, 8'h2C, "two keys row"};

        n_cmp = 0; n_err = 0; pulses = 0; cyc = 0;
        for (int i = 0; i < 4; i++) key_mask[i] = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset rows", 32'(kp_if.rows), 32'h8);
        check("reset total_val", 32'(kp_if.total_val), 32'h0F);
        check("reset key_valid", 32'(kp_if.key_valid), 32'd0);
        check("reset key_new", 32'(kp_if.key_new), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        scan_check(20, "idle scan");

        for (int i = 0; i < 5; i++)
            press_check(tbl[i].row, tbl[i].mask, tbl[i].exp_tv, 10, tbl[i].nm);

        // bounce: candidate never stays stable long enough
        #1 p0 = pulses;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            key_mask[2] = (((i / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (kp_if.key_valid !== 1'b0) lows++;
        end
        key_mask[2] = 4'h0;
        repeat (20) @(negedge clk);
        #1;
        check("bounce key_new", 32'(pulses - p0), 32'd0);
        check("bounce key_valid", 32'(lows), 32'd0);
        press_check(2, 4'b0010, 8'h4D, 10, "bounce then stable");

        // release glitch shorter than the debounce window
        #1 p0 = pulses;
        key_mask[3] = 4'b1000;
        wait_new(200, ok);
        check("glitch accepted", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        key_mask[3] = 4'h0;
        repeat (5) @(negedge clk);
        key_mask[3] = 4'b1000;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (kp_if.key_valid !== 1'b1) lows++;
        end
        #1;
        check("glitch key_valid held", 32'(lows), 32'd0);
        check("glitch key_new count", 32'(pulses - p0), 32'd1);
        check("glitch total_val", 32'(kp_if.total_val), 32'h87);
        key_mask[3] = 4'h0;
        wait_valid_low(60, ok);
        check("glitch released", 32'(ok), 32'd1);

        // long hold: auto-repeat when built in, otherwise a single strobe
        #1 p0 = pulses;
        key_mask[0] = 4'b0100;
        wait_new(200, ok);
        check("hold accepted", 32'(ok), 32'd1);
        #1 t0 = cyc;
        repeat (60) @(negedge clk);
        #1;
`ifdef KEY_REPEAT_EN
        n_exp = 4;
`else
        n_exp = 1;
`endif
        check("hold key_new count", 32'(pulses - p0), 32'(n_exp));
        check("hold total_val", 32'(kp_if.total_val), 32'h1B);
        if (pulse_q.size() >= n_exp && n_exp > 1)
            for (int i = pulse_q.size() - n_exp + 1; i < pulse_q.size(); i++)
                check("repeat spacing", 32'(pulse_q[i] - pulse_q[i - 1]), 32'd16);
        check("hold first strobe time", 32'(pulse_q[pulse_q.size() - n_exp]), 32'(t0));
        key_mask[0] = 4'h0;
        wait_valid_low(60, ok);
        check("hold released", 32'(ok), 32'd1);

        // reset during HELD takes effect immediately
        key_mask[2] = 4'b0010;
        wait_new(200, ok);
        check("midheld accepted", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midheld rows", 32'(kp_if.rows), 32'h8);
        check("midheld total_val", 32'(kp_if.total_val), 32'h0F);
        check("midheld key_valid", 32'(kp_if.key_valid), 32'd0);
        check("midheld key_new", 32'(kp_if.key_new), 32'd0);
        key_mask[2] = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        scan_check(6, "post reset scan");

        // random presses against the keypad rule total_val = {row, ~pressed columns}
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(3, 0);
            m = 4'($urandom_range(15, 1));
            repeat ($urandom_range(15, 0)) @(negedge clk);
            press_check(r, m, {4'(1 << r), ~m}, $urandom_range(10, 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 matrix keypad front end.
- Drives one row at a time, samples the active-low columns, and debounces presses and releases.
- Presents the packed {row, column} word to the downstream key decoder, with a level valid and a one-cycle new-key strobe.
- Sits between the keypad pins and the key decoder; its output feeds the display/entry logic.

Parameters:
- SCAN_DIV, 16: clock cycles each row is driven (dwell) before sampling and advancing; minimum 4.
- DEBOUNCE_CNT, 8: consecutive stable cycles required to accept a press or a release; minimum 2.
- REPEAT_CYCLES, 64: auto-repeat interval in cycles; used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cols_n  input  4  raw keypad columns, active-low, asynchronous to clk.
- rows  output  4  one-hot row select; bit 3 = top row (1,2,3,A).
- total_val  output  8  {rows, cols_n_sync} captured at accepted press; feeds the decoder.
- key_valid  output  1  high while a debounced key is held.
- key_new  output  1  one-cycle pulse when a key is accepted.

Behaviour:
- Synchronizer: cols_n passes through a 2-flop synchronizer (cols_s), reset to 4'hF. All decisions use cols_s.
- Reset: clears all state, takes effect immediately, and aborts any scan, debounce or hold in progress. Reset values:
  - rows = 4'b1000, total_val = 8'h0F, key_valid = 0, key_new = 0.
  - FSM = SCAN; dwell, debounce and repeat counters = 0.
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On the cycle the count equals SCAN_DIV-1:
    - If cols_s == 4'hF: rotate rows right (1000→0100→0010→0001→1000) and reset the dwell counter.
    - Otherwise: latch cand = cols_s, freeze rows, go to DEBOUNCE with the debounce counter at 0.
- DEBOUNCE:
  - Each cycle cols_s == cand increments the debounce counter.
  - Any mismatch returns to SCAN: rows advance, no output change.
  - On the cycle the counter reaches DEBOUNCE_CNT-1 with a match:
    - total_val <= {rows, cand}, key_valid <= 1, key_new <= 1 for exactly one cycle.
    - Go to HELD.
- HELD:
  - rows stay frozen; total_val stays constant.
  - Column changes that leave a column low are ignored: no new pulse, no total_val update.
  - cols_s == 4'hF moves to RELEASE with the debounce counter at 0.
- RELEASE:
  - Counts consecutive cycles of cols_s == 4'hF.
  - Any low column returns to HELD: no key_new, key_valid stays 1.
  - On reaching DEBOUNCE_CNT-1: key_valid <= 0, rows advance one step, dwell counter = 0, go to SCAN.
  - total_val keeps its last value.
- Multiple keys:
  - Within one row: cand holds the full pattern; the decoder's column priority resolves it.
  - Keys in other rows are invisible while the row is frozen.
- Press latency, measured from when cols_n goes low and stays low with its row driven: 2 sync cycles, plus wait to the end of the dwell, plus DEBOUNCE_CNT cycles, to key_new.
- key_new and key_valid are registered outputs.
- No combinational path from cols_n to any output.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In HELD, a repeat counter runs 0..REPEAT_CYCLES-1.
  - On wrap, key_new pulses for one cycle; total_val is unchanged.
  - The counter clears on entry to HELD and while in RELEASE.
  - If RELEASE returns to HELD, the count restarts from 0.
- Not defined: no repeat logic is built; key_new pulses exactly once per accepted press.

Test Plan:
- Reset mid-HELD (SCAN_DIV=4, DEBOUNCE_CNT=8):
  - Assert reset while key_valid=1.
  - Expect immediately: rows=1000, total_val=8'h0F, key_valid=0, key_new=0.
  - After release of reset, scanning resumes from row 1000.
- Idle scan, cols_n=4'hF: rows cycles 1000,0100,0010,0001,1000, each held exactly 4 cycles; key_valid and key_new stay 0.
- Clean press of '5' (row 0100, cols_n=4'b1101 held while that row is driven):
  - Exactly one key_new pulse; total_val=8'h4D; key_valid=1.
  - Release for ≥8 cycles → key_valid=0; rows advance to 0010.
- Bounce:
  - cols_n toggles 1101/1111 every 3 cycles during DEBOUNCE → no key_new; FSM back to SCAN.
  - Then stable 1101 → exactly one key_new.
- Release glitch: while holding 'A' (total_val=8'h87), cols_n goes high for 5 cycles, then low again → no second key_new; key_valid stays 1.
- With KEY_REPEAT_EN, REPEAT_CYCLES=16: hold 'F' (total_val=8'h1B) for 60 cycles after acceptance → key_new at acceptance plus 3 repeats, spaced 16 cycles apart.
